// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
// Shared definitions for the stopwatch controller:
//   - sw_state_t      : 2-bit FSM state encoding (IDLE, RUN, PAUSE, LAP)
//   - DIGIT_W         : width of one BCD display digit
//   - BCD_MAX_UNITS   : terminal count of a units digit (9)
//   - BCD_MAX_TENS    : terminal count of a tens digit (5)
//   - bcd_next()      : value a BCD digit takes when it is enabled
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS  = 4'd5;

    // At or beyond terminal count the digit wraps to 0, so a corrupted
    // out-of-range value recovers on its next enable instead of counting on.
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] digit,
                                                     input logic [DIGIT_W-1:0] max);
        return (digit >= max) ? '0 : digit + 1'b1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit of the stopwatch cascade, counting 0..MAX.
// Ports:
//   clk    : system clock, rising edge
//   clear  : asynchronous active-high clear, forces digit to 0
//   en     : count enable (tick or carry from the lower digit)
//   digit  : current digit value
//   carry  : combinational, high when enabled at terminal count, so every
//            digit in the chain wraps on the same edge
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import stopwatch_ctrl_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_UNITS
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               en,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    assign carry = en && (digit >= MAX);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            digit <= '0;
        end else if (en) begin
            digit <= bcd_next(digit, MAX);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// MM:SS stopwatch with run/pause, lap freeze and zeroing.
// Ports:
//   clk            : system clock, rising edge
//   clear          : asynchronous active-high reset of the whole block
//   start_stop     : one-cycle pulse, toggles running/paused
//   lap_reset      : one-cycle pulse; lap freeze/unfreeze while running,
//                    zero the count while paused
//   sec_u, sec_t,
//   min_u, min_t   : BCD display digits (live count, or lap snapshot in LAP)
//   running        : high in RUN and LAP
//   lap_active     : high in LAP
//   rollover       : one-cycle pulse aligned with the 59:59 -> 00:00 wrap
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 50_000_000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam int unsigned PRESC_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_TICK - 1);

    sw_state_t          state, state_next;
    logic               armed;
    logic               ss_eff;
    logic [PRESC_W-1:0] presc;
    logic               counting;
    logic               tick;
    logic               zero_q;
    logic               digit_clear;

    logic [DIGIT_W-1:0] live_su, live_st, live_mu, live_mt;
    logic [DIGIT_W-1:0] snap_su, snap_st, snap_mu, snap_mt;
    logic               carry_su, carry_st, carry_mu, carry_mt;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // start_stop is masked on the first edge after clear releases, so a
    // pulse overlapping reset release cannot start the watch.
    assign ss_eff = start_stop && armed;

    // NOTE: the default assignment first keeps this combinational process
    // from inferring a latch on paths that do not assign state_next.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (ss_eff) state_next = ST_RUN;
            ST_RUN:   if (ss_eff) state_next = ST_PAUSE;
                      else if (lap_reset) state_next = ST_LAP;
            ST_PAUSE: if (ss_eff) state_next = ST_RUN;
                      else if (lap_reset) state_next = ST_IDLE;
            ST_LAP:   if (ss_eff) state_next = ST_PAUSE;
                      else if (lap_reset) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running    = 1'b0;
        lap_active = 1'b0;
        sec_u      = live_su;
        sec_t      = live_st;
        min_u      = live_mu;
        min_t      = live_mt;
        unique case (state)
            ST_RUN:  running = 1'b1;
            ST_LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
                sec_u      = snap_su;
                sec_t      = snap_st;
                min_u      = snap_mu;
                min_t      = snap_mt;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------- prescaler
    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            presc <= '0;
        end else if (state == ST_IDLE) begin
            presc <= '0;
        end else if (counting) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // -------------------------------------------------------- digit chain
    // Zeroing from PAUSE reuses the digits' clear input. The request is
    // registered so the clear stays glitch-free; the digits drop to 0 right
    // after the PAUSE->IDLE edge and stay there, since nothing enables them
    // in IDLE.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= (state == ST_PAUSE) && (state_next == ST_IDLE);
        end
    end

    assign digit_clear = clear || zero_q;

    bcd_digit_counter #(.MAX(BCD_MAX_UNITS)) u_sec_u (
        .clk(clk), .clear(digit_clear), .en(tick),     .digit(live_su), .carry(carry_su)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_TENS)) u_sec_t (
        .clk(clk), .clear(digit_clear), .en(carry_su), .digit(live_st), .carry(carry_st)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_UNITS)) u_min_u (
        .clk(clk), .clear(digit_clear), .en(carry_st), .digit(live_mu), .carry(carry_mu)
    );
    bcd_digit_counter #(.MAX(BCD_MAX_TENS)) u_min_t (
        .clk(clk), .clear(digit_clear), .en(carry_mu), .digit(live_mt), .carry(carry_mt)
    );

    // Registered so the pulse lines up with the 00:00 value.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rollover <= 1'b0;
        end else begin
            rollover <= carry_mt;
        end
    end

    // ----------------------------------------------------- lap snapshot
    // Loaded with the post-edge live value so a tick landing on the
    // RUN->LAP edge is included in the frozen display.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            snap_su <= '0;
            snap_st <= '0;
            snap_mu <= '0;
            snap_mt <= '0;
        end else if ((state == ST_RUN) && (state_next == ST_LAP)) begin
            snap_su <= tick     ? bcd_next(live_su, BCD_MAX_UNITS) : live_su;
            snap_st <= carry_su ? bcd_next(live_st, BCD_MAX_TENS)  : live_st;
            snap_mu <= carry_st ? bcd_next(live_mu, BCD_MAX_UNITS) : live_mu;
            snap_mt <= carry_mu ? bcd_next(live_mt, BCD_MAX_TENS)  : live_mt;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Scoreboard bench for stopwatch_ctrl with CLK_PER_TICK = 4. Each expected
// observation {rollover, lap_active, running, min_t, min_u, sec_t, sec_u} is
// built from an elapsed-seconds value and queued when stimulus is driven,
// then popped and compared when the DUT output is sampled (negedge).
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int CPT = 4;

    logic       clk = 1'b0;
    logic       clear;
    logic       start_stop;
    logic       lap_reset;
    logic [3:0] sec_u, sec_t, min_u, min_t;
    logic       running, lap_active, rollover;
    logic [18:0] dut_obs;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [18:0] obs;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_PER_TICK(CPT)) dut (
        .clk        (clk),
        .clear      (clear),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .sec_u      (sec_u),
        .sec_t      (sec_t),
        .min_u      (min_u),
        .min_t      (min_t),
        .running    (running),
        .lap_active (lap_active),
        .rollover   (rollover)
    );

    assign dut_obs = {rollover, lap_active, running, min_t, min_u, sec_t, sec_u};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [18:0] obs_of(input int secs, input bit run, input bit lap, input bit roll);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {roll, lap, run, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic expect_obs(input string tag, input int secs, input bit run, input bit lap, input bit roll);
        exp_t e;
        e.tag = tag;
        e.obs = obs_of(secs, run, lap, roll);
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, 32'(dut_obs), 32'(e.obs));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse(input bit ss, input bit lr);
        start_stop = ss;
        lap_reset  = lr;
        step(1);
        start_stop = 1'b0;
        lap_reset  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear      = 1'b1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        step(2);
        expect_obs("reset_state", 0, 0, 0, 0); sample();

        // Release clear; start_stop on the first edge must be ignored.
        clear = 1'b0;
        expect_obs("ss_first_edge_ignored", 0, 0, 0, 0); pulse(1, 0); sample();
        expect_obs("lr_in_idle_ignored", 0, 0, 0, 0);    pulse(0, 1); sample();
        expect_obs("start_running", 0, 1, 0, 0);         pulse(1, 0); sample();
        expect_obs("before_first_tick", 0, 1, 0, 0);     step(CPT - 1); sample();
        expect_obs("first_tick", 1, 1, 0, 0);            step(1); sample();

        // Digit cascade boundaries.
        expect_obs("at_00_09", 9, 1, 0, 0);   step(CPT * 8);  sample();
        expect_obs("carry_00_10", 10, 1, 0, 0); step(CPT);    sample();
        expect_obs("at_00_59", 59, 1, 0, 0); step(CPT * 49); sample();
        expect_obs("carry_01_00", 60, 1, 0, 0); step(CPT);    sample();
        expect_obs("at_59_59", 3599, 1, 0, 0); step(CPT * (3599 - 60)); sample();
        expect_obs("rollover_wrap", 0, 1, 0, 1); step(CPT); sample();
        expect_obs("rollover_one_cycle", 0, 1, 0, 0); step(1); sample();

        // Lap freeze: reach 00:05 (prescaler is one cycle past the wrap).
        expect_obs("at_00_05", 5, 1, 0, 0);   step((CPT - 1) + CPT * 4); sample();
        expect_obs("lap_enter", 5, 1, 1, 0);  pulse(0, 1); sample();
        expect_obs("lap_frozen", 5, 1, 1, 0); step(8); sample();
        expect_obs("lap_exit_live", 7, 1, 0, 0); pulse(0, 1); sample();

        // Pause, hold, zero, and start_stop priority.
        expect_obs("pause", 7, 0, 0, 0);         pulse(1, 0); sample();
        expect_obs("pause_hold", 7, 0, 0, 0);    step(20); sample();
        expect_obs("pause_to_idle", 0, 0, 0, 0); pulse(0, 1); sample();
        expect_obs("idle_hold", 0, 0, 0, 0);     step(1); sample();
        expect_obs("restart", 0, 1, 0, 0);       pulse(1, 0); sample();
        expect_obs("pause_again", 0, 0, 0, 0);   pulse(1, 0); sample();
        expect_obs("ss_priority", 0, 1, 0, 0);   pulse(1, 1); sample();
        // One prescaler cycle was spent on the RUN->PAUSE edge.
        expect_obs("resume_tick", 1, 1, 0, 0);   step(CPT - 1); sample();

        // Reach 12:34, freeze it, then clear asynchronously between edges.
        expect_obs("at_12_34", 754, 1, 0, 0);  step(CPT * 753); sample();
        expect_obs("lap_12_34", 754, 1, 1, 0); pulse(0, 1); sample();
        #2;
        clear = 1'b1;
        #1;
        expect_obs("async_clear", 0, 0, 0, 0); sample();
        expect_obs("clear_held", 0, 0, 0, 0);  step(1); sample();
        clear = 1'b0;

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 50000000, clock cycles per 1 s count tick (legal range 2 or more).
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port start_stop, input, 1, one-cycle pulse that toggles between running and paused.
REQ-005 SHALL have port lap_reset, input, 1, one-cycle pulse; freezes or unfreezes the display while running, and zeroes the count while paused.
REQ-006 SHALL have ports sec_u, sec_t, min_u, min_t, output, 4 each, BCD display digits (sec_t and min_t are 0..5; sec_u and min_u are 0..9).
REQ-007 SHALL have port running, output, 1, high in RUN and LAP states.
REQ-008 SHALL have port lap_active, output, 1, high in LAP state.
REQ-009 SHALL have port rollover, output, 1, one-cycle pulse when the count wraps 59:59 -> 00:00.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, PAUSE, LAP.
REQ-011 SHALL transition IDLE->RUN on start_stop, RUN->PAUSE on start_stop, PAUSE->RUN on start_stop, RUN->LAP on lap_reset, LAP->RUN on lap_reset, LAP->PAUSE on start_stop, and PAUSE->IDLE on lap_reset (count zeroed the same edge).
REQ-012 SHALL give start_stop priority when start_stop and lap_reset are asserted in the same cycle; lap_reset is ignored that cycle.
REQ-013 SHALL ignore lap_reset in IDLE.
REQ-014 SHALL run a prescaler 0..CLK_PER_TICK-1 only in RUN and LAP, holding its value in PAUSE and clearing to 0 in IDLE.
REQ-015 SHALL generate tick for one cycle when the prescaler equals CLK_PER_TICK-1; the prescaler wraps to 0 on that same edge.
REQ-016 SHALL advance the count on the clock edge at which tick is high; latency from tick to the updated digit is 1 cycle.
REQ-017 SHALL cascade the digits: sec_u 0..9 -> sec_t 0..5 -> min_u 0..9 -> min_t 0..5.
REQ-018 SHALL have each digit wrap to 0 and carry when it is at terminal count and enabled.
REQ-019 SHALL make each carry combinational (terminal count AND enable), so that all digits wrap on the same edge.
REQ-020 SHALL, at 59:59 with tick, go to 00:00 and pulse rollover for exactly one cycle, aligned with the 00:00 value.
REQ-021 SHALL drive the outputs from a live count register in IDLE, RUN and PAUSE, and from a lap snapshot register in LAP.
REQ-022 SHALL load the lap snapshot with the live count on the RUN->LAP edge, including any increment occurring on that edge.
REQ-023 SHALL keep the live count advancing during LAP.
REQ-024 SHALL NOT change the count in PAUSE.
REQ-025 SHALL NOT advance any digit beyond its maximum; an out-of-range digit value (unreachable) wraps to 0 on its next enable.

Reset
REQ-026 SHALL, while clear is high, asynchronously force: state IDLE; prescaler 0; all live and snapshot digits 0; running 0; lap_active 0; rollover 0.
REQ-027 SHALL abort any operation in progress when clear is asserted (mid-run, mid-lap or mid-tick); no carry propagates.
REQ-028 SHALL ignore start_stop during the first clk edge after clear deasserts (reset not visible to the FSM); it is honoured from the second edge.

Structure
REQ-029 SHALL place in a shared package: the FSM state encoding (2 bits), the BCD max constants (9, 5), and the display-digit width (4).
REQ-030 SHALL use one sub-module, bcd_digit_counter, parameter MAX, ports clk, clear, en, digit[3:0], carry, instantiated four times (MAX = 9, 5, 9, 5).
REQ-031 SHALL keep the prescaler, FSM and snapshot register in stopwatch_ctrl.

Verification (bench uses CLK_PER_TICK=4)
REQ-032 SHALL test reset then start_stop: the first sec_u increment occurs 4 cycles after the start pulse, and running=1.
REQ-033 SHALL test a preload of 00:09 (via ticks) plus one tick: result is 00:10; a count of 00:59 plus one tick: result is 01:00.
REQ-034 SHALL test 59:59 plus one tick: result is 00:00 and rollover is high for exactly 1 cycle.
REQ-035 SHALL test RUN at 00:05, lap_reset, then 8 cycles: outputs hold 00:05 with lap_active=1; a second lap_reset shows 00:07.
REQ-036 SHALL test RUN, start_stop (PAUSE), 20 idle cycles: the count is unchanged; a following lap_reset gives 00:00 and IDLE; start_stop and lap_reset asserted in the same cycle from PAUSE go to RUN.
REQ-037 SHALL test clear asserted asynchronously mid-cycle while in LAP at 12:34: all outputs 0 immediately, without waiting for a clk edge.
